bit_scanner: RTL and testbench
==============================

BIT_SCANNER -- requirements
Module: bit_scanner

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning input word width, legal range 2..256.
REQ-002 SHALL provide parameter IDX_W, default $clog2(WIDTH), meaning index output width.
REQ-003 SHALL provide parameter MSB_FIRST, default 1, meaning scan order: 1 = highest set bit first, 0 = lowest set bit first.
REQ-004 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port ena  input  1  global enable; no transfer or state change while low.
REQ-007 SHALL provide port in_valid  input  1  in_data holds a word to scan.
REQ-008 SHALL provide port in_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL provide port in_data  input  WIDTH  word to scan.
REQ-010 SHALL provide port out_valid  output  1  out_idx/out_last/out_none are valid.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts current beat.
REQ-012 SHALL provide port out_idx  output  IDX_W  bit position of current set bit.
REQ-013 SHALL provide port out_last  output  1  current beat is final beat of the word.
REQ-014 SHALL provide port out_none  output  1  accepted word was all zeros.
REQ-015 SHALL provide port busy  output  1  high while in SCAN.

Function
REQ-016 SHALL implement two states, IDLE and SCAN, plus a WIDTH-bit pending register.
REQ-017 IDLE: SHALL drive in_ready = ena and out_valid = 0.
REQ-018 IDLE: when in_valid & in_ready, SHALL load in_data into pending and move to SCAN on the same edge.
REQ-019 SCAN: SHALL drive in_ready = 0 and out_valid = ena; the first beat is valid the cycle after acceptance.
REQ-020 SCAN, pending nonzero: out_idx SHALL be the highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of pending; out_none = 0; out_last = 1 exactly when pending has one bit set.
REQ-021 SCAN, pending zero from acceptance: SHALL emit one beat with out_idx = 0, out_none = 1, out_last = 1.
REQ-022 On out_valid & out_ready, SHALL clear the reported bit in pending; if out_last, SHALL return to IDLE.
REQ-023 Throughput SHALL be one index per cycle with out_ready held high; in_ready SHALL reassert the cycle after the last beat transfers.
REQ-024 Stall (out_ready = 0): out_idx, out_last and out_none SHALL hold stable and pending SHALL be unchanged.
REQ-025 ena = 0: in_ready and out_valid SHALL be 0 and all state SHALL hold; scanning resumes unchanged when ena returns.
REQ-026 in_valid in SCAN SHALL be ignored; the word SHALL not be captured.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE and pending = 0; out_valid, out_idx, out_last, out_none and busy SHALL read 0; pop_count (when present) SHALL read 0.
REQ-028 Reset mid-scan SHALL discard the remaining bits; after release, the block SHALL be in IDLE with in_ready = ena.

Configuration
REQ-029 With macro BIT_SCANNER_POPCOUNT_EN defined, SHALL add port pop_count  output  IDX_W+1, registered on acceptance as the number of set bits in in_data and held until the next acceptance.
REQ-030 Without BIT_SCANNER_POPCOUNT_EN, the pop_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=16, MSB_FIRST=1, in_data=0x8421, out_ready=1 -> beats out_idx 15,10,5,0 on consecutive cycles; out_last only on 0; in_ready=1 the next cycle.
REQ-032 in_data=0x0000 -> single beat out_none=1, out_idx=0, out_last=1, then IDLE.
REQ-033 MSB_FIRST=0, in_data=0x8001, out_ready pattern 0,1,0,1 -> out_idx 0 held through the stall, then 15 with out_last=1.
REQ-034 in_data=0xFFFF, rst_n low after the first beat -> out_valid=0 immediately, without waiting for a clock edge; after release, in_ready=1 and busy=0.
REQ-035 ena=0 for 3 cycles mid-scan of 0x00F0 -> no beats and no pending change; resumes at the held index once ena=1.
REQ-036 BIT_SCANNER_POPCOUNT_EN defined, in_data=0xFFFF -> pop_count=16 (5'b10000) the cycle after acceptance, held through all 16 beats.

Source files
------------

// File: rtl/bit_scanner.sv
// ---------------------------------------------------------------------------
// bit_scanner
//
// Accepts a WIDTH-bit word and reports the positions of its set bits one per
// cycle, highest first (MSB_FIRST=1) or lowest first (MSB_FIRST=0). An
// all-zero word produces a single beat flagged out_none.
//
// Optional feature: define BIT_SCANNER_POPCOUNT_EN to add the pop_count
// output, which is captured at acceptance as the number of set bits in the
// accepted word and held until the next acceptance.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   global enable; nothing transfers or changes while low
//   in_valid   in   in_data holds a word to scan
//   in_ready   out  word accepted this cycle when in_valid is also high
//   in_data    in   word to scan
//   out_valid  out  out_idx/out_last/out_none are valid
//   out_ready  in   consumer takes the current beat
//   out_idx    out  position of the reported set bit
//   out_last   out  final beat of the current word
//   out_none   out  accepted word was all zeros
//   busy       out  scan in progress
//   pop_count  out  (BIT_SCANNER_POPCOUNT_EN only) set-bit count of last word
// ---------------------------------------------------------------------------
module bit_scanner #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
`ifdef BIT_SCANNER_POPCOUNT_EN
    ,
    output logic [IDX_W:0]   pop_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;

    logic             w_scan;
    logic             w_empty;
    logic             w_single;
    logic             w_last;
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_clear_mask;

    // Position of the next bit to report, in the configured scan order.
    // The loop direction makes the last match win, which is the wanted end.
    function automatic logic [IDX_W-1:0] f_find(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

`ifdef BIT_SCANNER_POPCOUNT_EN
    function automatic logic [IDX_W:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction
`endif

    assign w_scan       = (r_state == SCAN);
    assign w_empty      = (r_pending == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    assign w_single     = !w_empty && ((r_pending & (r_pending - WIDTH'(1))) == '0);
    // In SCAN an empty pending register only happens for an all-zero word,
    // because the beat that clears the final bit also leaves SCAN.
    assign w_last       = w_empty || w_single;
    assign w_idx        = f_find(r_pending);
    assign w_clear_mask = ~({{(WIDTH-1){1'b0}}, 1'b1} << w_idx);

    assign busy      = w_scan;
    assign in_ready  = ena && !w_scan;
    assign out_valid = ena && w_scan;
    assign out_idx   = w_scan ? w_idx : '0;
    assign out_last  = w_scan && w_last;
    assign out_none  = w_scan && w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
`ifdef BIT_SCANNER_POPCOUNT_EN
            pop_count <= '0;
`endif
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pending <= in_data;
                        r_state   <= SCAN;
`ifdef BIT_SCANNER_POPCOUNT_EN
                        pop_count <= f_popcount(in_data);
`endif
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        r_pending <= r_pending & w_clear_mask;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scanner.sv
module tb_bit_scanner;

    localparam int W  = 16;
    localparam int IW = 4;

    typedef struct {
        int idx;
        int last;
        int none;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n, ena, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic           m_in_ready, m_out_valid, m_out_last, m_out_none, m_busy;
    logic [IW-1:0]  m_out_idx;
    logic           l_in_ready, l_out_valid, l_out_last, l_out_none, l_busy;
    logic [IW-1:0]  l_out_idx;
`ifdef BIT_SCANNER_POPCOUNT_EN
    logic [IW:0]    m_pop, l_pop;
`endif

    beat_t q_m[$];
    beat_t q_l[$];
    int    exp_pop;
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    bit_scanner #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_last(m_out_last), .out_none(m_out_none), .busy(m_busy)
`ifdef BIT_SCANNER_POPCOUNT_EN
        , .pop_count(m_pop)
`endif
    );

    bit_scanner #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_none(l_out_none), .busy(l_busy)
`ifdef BIT_SCANNER_POPCOUNT_EN
        , .pop_count(l_pop)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the set positions, then order them per scan direction.
    task automatic push_word(input logic [W-1:0] w);
        int    pos[$];
        beat_t b;
        for (int i = 0; i < W; i++) if (w[i]) pos.push_back(i);
        exp_pop = pos.size();
        if (pos.size() == 0) begin
            b.idx = 0; b.last = 1; b.none = 1;
            q_m.push_back(b);
            q_l.push_back(b);
        end else begin
            for (int k = 0; k < pos.size(); k++) begin
                b.none = 0;
                b.last = (k == pos.size() - 1) ? 1 : 0;
                b.idx  = pos[k];
                q_l.push_back(b);
                b.idx  = pos[pos.size() - 1 - k];
                q_m.push_back(b);
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit scanning = (q_m.size() != 0);
            automatic int pop_before = exp_pop;
            chk("msb_in_ready", m_in_ready, (ena && !scanning) ? 1 : 0);
            chk("lsb_in_ready", l_in_ready, (ena && !scanning) ? 1 : 0);
            chk("msb_out_valid", m_out_valid, (ena && scanning) ? 1 : 0);
            chk("lsb_out_valid", l_out_valid, (ena && scanning) ? 1 : 0);
            chk("msb_busy", m_busy, scanning ? 1 : 0);
            chk("lsb_busy", l_busy, scanning ? 1 : 0);
            if (scanning && ena) begin
                chk("msb_idx",  m_out_idx,  q_m[0].idx);
                chk("msb_last", m_out_last, q_m[0].last);
                chk("msb_none", m_out_none, q_m[0].none);
                chk("lsb_idx",  l_out_idx,  q_l[0].idx);
                chk("lsb_last", l_out_last, q_l[0].last);
                chk("lsb_none", l_out_none, q_l[0].none);
                if (out_ready) begin
                    void'(q_m.pop_front());
                    void'(q_l.pop_front());
                end
            end else if (!scanning && ena && in_valid) begin
                push_word(in_data);
            end
`ifdef BIT_SCANNER_POPCOUNT_EN
            chk("msb_pop_count", m_pop, pop_before);
            chk("lsb_pop_count", l_pop, pop_before);
`endif
        end
    end

    task automatic accept_word(input logic [W-1:0] w);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = m_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((m_busy || l_busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        case ($urandom_range(0, 5))
            0:       w = '0;
            1:       w = W'(1) << $urandom_range(0, W - 1);
            2:       w = '1;
            default: w = W'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        exp_pop = 0;
        #2;
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_out_idx", m_out_idx, 0);
        chk("rst_out_last", m_out_last, 0);
        chk("rst_out_none", m_out_none, 0);
        chk("rst_in_ready", m_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // One index per cycle, then the all-zero word
        accept_word(16'h8421);
        wait_idle();
        accept_word(16'h0000);
        wait_idle();

        // Consumer stall pattern 0,1,0,1
        out_ready = 1'b0;
        accept_word(16'h8001);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle();

        // Enable gap mid-scan
        accept_word(16'h00F0);
        @(posedge clk); #1; ena = 1'b0;
        repeat (3) @(posedge clk);
        #1; ena = 1'b1;
        wait_idle();

        // Reset mid-scan takes effect without a clock edge
        accept_word(16'hFFFF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_msb_out_valid", m_out_valid, 0);
        chk("midrst_lsb_out_valid", l_out_valid, 0);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_out_idx", m_out_idx, 0);
`ifdef BIT_SCANNER_POPCOUNT_EN
        chk("midrst_pop_count", m_pop, 0);
`endif
        q_m.delete();
        q_l.delete();
        exp_pop = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", m_in_ready, 1);
        chk("postrst_busy", m_busy, 0);
        @(posedge clk); #1;

        // Full word: pop_count (when present) held across all beats
        accept_word(16'hFFFF);
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            ena       = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) != 0;
            in_data   = rand_word();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; ena = 1'b1; out_ready = 1'b1;
        wait_idle();
        chk("final_queue_empty", q_m.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
